// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_bin_seq
//  Description : Sequential packed-BCD to binary converter (reverse
//                double-dabble: shift right, then subtract 3 from every BCD
//                digit that reached 8 or more). One step per clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_to_bin_seq #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int c_bcd_w  = 4 * DIGITS;
   localparam int c_work_w = c_bcd_w + BIN_W;
   localparam int c_cnt_w  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BIN_W - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_CONV = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_work_w-1:0]  r_work;
   logic [c_work_w-1:0]  w_work_nxt;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [c_cnt_w-1:0]   w_cnt_nxt;
   logic                 w_busy_nxt;
   logic                 w_done_nxt;
   logic                 w_err_nxt;
   logic [BIN_W-1:0]     w_bin_nxt;

   // One conversion step: whole register shifted right, then per-digit fixup.
   logic [c_work_w-1:0]  w_shift;
   logic [c_work_w-1:0]  w_step;
   logic [DIGITS-1:0]    w_dig_ok;
   logic                 w_bcd_ok;

   assign w_shift             = r_work >> 1;
   assign w_step[BIN_W-1:0]   = w_shift[BIN_W-1:0];
   assign w_bcd_ok            = &w_dig_ok;

   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_digit
         logic [3:0] w_sd;
         assign w_sd = w_shift[BIN_W + 4*k +: 4];
         // A digit of 8..15 after the shift came from an odd upper digit;
         // removing 3 restores the decimal weight (no borrow between digits).
         assign w_step[BIN_W + 4*k +: 4] = (w_sd >= 4'd8) ? (w_sd - 4'd3) : w_sd;
         assign w_dig_ok[k] = (bcd_in[4*k +: 4] <= 4'd9);
      end
   endgenerate

   // Next-state and output decode; done is a pulse so it defaults low.
   always_comb begin
      w_state_nxt = r_state;
      w_work_nxt  = r_work;
      w_cnt_nxt   = r_cnt;
      w_busy_nxt  = busy;
      w_done_nxt  = 1'b0;
      w_err_nxt   = err;
      w_bin_nxt   = bin_out;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_bcd_ok) begin
                  w_work_nxt  = {bcd_in, {BIN_W{1'b0}}};
                  w_cnt_nxt   = '0;
                  w_busy_nxt  = 1'b1;
                  w_state_nxt = S_CONV;
               end else begin
                  // Bad digit: report immediately without converting.
                  w_bin_nxt  = '0;
                  w_err_nxt  = 1'b1;
                  w_done_nxt = 1'b1;
               end
            end
         end
         S_CONV: begin
            w_work_nxt = w_step;
            w_cnt_nxt  = r_cnt + c_cnt_w'(1);
            if (r_cnt == c_last) begin
               // Take the result from this step, not the registered copy.
               w_bin_nxt   = w_step[BIN_W-1:0];
               w_err_nxt   = 1'b0;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and output registers; clr overrides everything, aborting a conversion.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= S_IDLE;
         r_work  <= '0;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         bin_out <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_work  <= w_work_nxt;
         r_cnt   <= w_cnt_nxt;
         busy    <= w_busy_nxt;
         done    <= w_done_nxt;
         err     <= w_err_nxt;
         bin_out <= w_bin_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_to_bin_seq
//  Description : Directed self-checking bench for bcd_to_bin_seq.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_to_bin_seq;

   localparam int c_digits = 3;
   localparam int c_bin_w  = 10;
   localparam int c_bcd_w  = 4 * c_digits;

   logic                 clk;
   logic                 clr;
   logic                 start;
   logic [c_bcd_w-1:0]   bcd_in;
   logic                 busy;
   logic                 done;
   logic [c_bin_w-1:0]   bin_out;
   logic                 err;

   int errors;
   int checks;
   int edges;
   int busy_cycles;

   bcd_to_bin_seq #(.DIGITS(c_digits), .BIN_W(c_bin_w)) dut (
      .clk     (clk),
      .clr     (clr),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .bin_out (bin_out),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Caller is at a negedge. Drives start for one edge, then counts edges
   // until done (bounded). Optionally re-pulses start with 12'h123 at edge rp.
   task automatic convert(input logic [c_bcd_w-1:0] val, input int rp);
      bcd_in      = val;
      start       = 1'b1;
      edges       = 0;
      busy_cycles = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         edges = i;
         if (busy) busy_cycles++;
         start = 1'b0;
         if (rp != 0 && i == rp) begin
            bcd_in = 12'h123;
            start  = 1'b1;
         end
         if (done) break;
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      clr    = 1'b1;
      start  = 1'b0;
      bcd_in = '0;

      // Reset, then idle with no start.
      repeat (2) @(negedge clk);
      clr = 1'b0;
      check("reset_busy", 32'(busy), 0);
      check("reset_done", 32'(done), 0);
      check("reset_err",  32'(err), 0);
      check("reset_bin",  32'(bin_out), 0);
      repeat (3) @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_done", 32'(done), 0);

      // 999: maximum valid value.
      convert(12'h999, 0);
      check("999_latency", 32'(edges), 11);
      check("999_busy_cycles", 32'(busy_cycles), 10);
      check("999_done", 32'(done), 1);
      check("999_bin", 32'(bin_out), 999);
      check("999_err", 32'(err), 0);
      check("999_bcd_field", 32'(dut.r_work[c_bcd_w+c_bin_w-1:c_bin_w]), 0);

      // Back-to-back conversions, each started on the previous done cycle.
      @(negedge clk);
      convert(12'h000, 0);
      check("b2b0_latency", 32'(edges), 11);
      check("b2b0_bin", 32'(bin_out), 0);
      convert(12'h255, 0);
      check("b2b1_latency", 32'(edges), 11);
      check("b2b1_bin", 32'(bin_out), 255);
      check("b2b1_bcd_field", 32'(dut.r_work[c_bcd_w+c_bin_w-1:c_bin_w]), 0);
      convert(12'h001, 0);
      check("b2b2_latency", 32'(edges), 11);
      check("b2b2_bin", 32'(bin_out), 1);
      convert(12'h100, 0);
      check("b2b3_latency", 32'(edges), 11);
      check("b2b3_bin", 32'(bin_out), 100);
      check("b2b3_busy_cycles", 32'(busy_cycles), 10);
      @(negedge clk);
      check("b2b_done_single", 32'(done), 0);

      // Invalid digit: one-edge error response, busy never rises.
      bcd_in = 12'h1A3;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("bad_done", 32'(done), 1);
      check("bad_err",  32'(err), 1);
      check("bad_bin",  32'(bin_out), 0);
      check("bad_busy", 32'(busy), 0);
      @(negedge clk);
      check("bad_done_clear", 32'(done), 0);
      check("bad_err_hold", 32'(err), 1);
      check("bad_busy_after", 32'(busy), 0);
      convert(12'h042, 0);
      check("after_bad_latency", 32'(edges), 11);
      check("after_bad_bin", 32'(bin_out), 42);
      check("after_bad_err", 32'(err), 0);

      // Start while busy with changed input is ignored.
      @(negedge clk);
      convert(12'h999, 3);
      check("ignore_latency", 32'(edges), 11);
      check("ignore_bin", 32'(bin_out), 999);
      @(negedge clk);
      check("ignore_busy_after", 32'(busy), 0);

      // clr aborts a conversion mid-flight.
      @(negedge clk);
      bcd_in = 12'h500;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("abort_busy_before", 32'(busy), 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_done", 32'(done), 0);
      check("abort_bin",  32'(bin_out), 0);
      edges = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) edges++;
      end
      check("abort_quiet", 32'(edges), 0);
      convert(12'h500, 0);
      check("restart_latency", 32'(edges), 11);
      check("restart_bin", 32'(bin_out), 500);
      check("restart_err", 32'(err), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
